// File: rtl/ntt_bram_tdp_clr.sv
`default_nettype none
// ============================================================================
// Module   : ntt_bram_tdp_clr
// Brief    : True dual-port NTT coefficient RAM with deterministic write
//            collision arbitration, read-valid strobes and a clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_bram_tdp_clr #(
  parameter int DATA_WIDTH = 12,
  parameter int ADW        = 5,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  output logic                  busy_o,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADW-1:0]        addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  vld_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADW-1:0]        addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  vld_b,
  output logic                  coll_o
);

  localparam int            c_depth = 2 ** ADW;
  localparam logic [ADW-1:0] c_last = ADW'(c_depth - 2);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADW-1:0]        r_cnt;
  logic [ADW-1:0]        w_cnt_nxt;
  logic                  w_busy;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  logic                  w_acc_a;
  logic                  w_acc_b;
  logic                  w_wr_a;
  logic                  w_wr_b;
  logic [ADW-1:0]        w_waddr_a;
  logic [ADW-1:0]        w_waddr_b;
  logic [DATA_WIDTH-1:0] w_wdata_a;
  logic [DATA_WIDTH-1:0] w_wdata_b;

  logic                  r_vld1_a;
  logic                  r_vld1_b;
  logic [DATA_WIDTH-1:0] r_dout1_a;
  logic [DATA_WIDTH-1:0] r_dout1_b;
  logic                  r_coll;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt + ADW'(2);
        if (r_cnt == c_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        if (clr_i) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign busy_o = w_busy;

  // ------------------------------------------------------- write arbitration
  assign w_acc_a = en_a & ~w_busy & ~rst_i;
  assign w_acc_b = en_b & ~w_busy & ~rst_i;

  always_comb begin
    w_wr_a    = 1'b0;
    w_wr_b    = 1'b0;
    w_waddr_a = addr_a;
    w_waddr_b = addr_b;
    w_wdata_a = din_a;
    w_wdata_b = din_b;
    if (w_busy) begin
      // The clear sweep owns both ports: two consecutive words per cycle.
      w_wr_a    = ~rst_i;
      w_wr_b    = ~rst_i;
      w_waddr_a = r_cnt;
      w_waddr_b = r_cnt + ADW'(1);
      w_wdata_a = '0;
      w_wdata_b = '0;
    end else begin
      w_wr_a = w_acc_a & we_a;
      // Port A wins a same-address write collision.
      w_wr_b = w_acc_b & we_b & ~(w_wr_a && (addr_a == addr_b));
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_a) begin
      r_mem[w_waddr_a] <= w_wdata_a;
    end
    if (w_wr_b) begin
      r_mem[w_waddr_b] <= w_wdata_b;
    end
  end

  // ------------------------------------------------------- read stage 1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld1_a  <= 1'b0;
      r_vld1_b  <= 1'b0;
      r_dout1_a <= '0;
      r_dout1_b <= '0;
      r_coll    <= 1'b0;
    end else begin
      r_vld1_a <= w_acc_a;
      r_vld1_b <= w_acc_b;
      // Memory is sampled before this edge's writes, so cross-port reads see old data.
      if (w_acc_a) begin
        r_dout1_a <= ((RD_MODE != 0) && we_a) ? din_a : r_mem[addr_a];
      end
      if (w_acc_b) begin
        r_dout1_b <= ((RD_MODE != 0) && we_b) ? din_b : r_mem[addr_b];
      end
      r_coll <= w_acc_a & we_a & w_acc_b & we_b & (addr_a == addr_b);
    end
  end

  assign coll_o = r_coll;

  // ------------------------------------------------------- optional stage 2
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_vld2_a;
      logic                  r_vld2_b;
      logic [DATA_WIDTH-1:0] r_dout2_a;
      logic [DATA_WIDTH-1:0] r_dout2_b;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_vld2_a  <= 1'b0;
          r_vld2_b  <= 1'b0;
          r_dout2_a <= '0;
          r_dout2_b <= '0;
        end else begin
          r_vld2_a <= r_vld1_a;
          r_vld2_b <= r_vld1_b;
          if (r_vld1_a) begin
            r_dout2_a <= r_dout1_a;
          end
          if (r_vld1_b) begin
            r_dout2_b <= r_dout1_b;
          end
        end
      end

      assign vld_a  = r_vld2_a;
      assign vld_b  = r_vld2_b;
      assign dout_a = r_dout2_a;
      assign dout_b = r_dout2_b;
    end else begin : g_no_out_reg
      assign vld_a  = r_vld1_a;
      assign vld_b  = r_vld1_b;
      assign dout_a = r_dout1_a;
      assign dout_b = r_dout1_b;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ntt_bram_tdp_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_bram_tdp_clr
// Brief    : Self-checking bench for ntt_bram_tdp_clr, read-first/latency-1
//            and write-first/latency-2 instances driven in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_bram_tdp_clr;

  localparam int DW    = 12;
  localparam int ADW   = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_i = 1'b0, clr_i = 1'b0;
  logic           en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [ADW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0]  din_a = '0, din_b = '0;

  logic           busy0, vld0_a, vld0_b, coll0;
  logic           busy1, vld1_a, vld1_b, coll1;
  logic [DW-1:0]  dout0_a, dout0_b, dout1_a, dout1_b;

  ntt_bram_tdp_clr #(.DATA_WIDTH(DW), .ADW(ADW), .RD_MODE(0), .OUT_REG(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy0),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout0_a), .vld_a(vld0_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout0_b), .vld_b(vld0_b),
    .coll_o(coll0));

  ntt_bram_tdp_clr #(.DATA_WIDTH(DW), .ADW(ADW), .RD_MODE(1), .OUT_REG(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy1),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout1_a), .vld_a(vld1_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout1_b), .vld_b(vld1_b),
    .coll_o(coll1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: contents array, remaining clear cycles, expected outputs.
  logic [DW-1:0] m_mem [DEPTH];
  int            clear_left = 0;
  logic          e0_va = 0, e0_vb = 0, e1_va = 0, e1_vb = 0, p_va = 0, p_vb = 0, e_coll = 0;
  logic [DW-1:0] e0_da = 0, e0_db = 0, e1_da = 0, e1_db = 0, p_da = 0, p_db = 0;

  task automatic model_step();
    bit            busy, acc_a, acc_b, wa, wb;
    logic [DW-1:0] old_a, old_b;
    if (rst_i) begin
      clear_left = DEPTH / 2;
      foreach (m_mem[i]) m_mem[i] = '0;
      {e0_va, e0_vb, e1_va, e1_vb, p_va, p_vb, e_coll} = '0;
      {e0_da, e0_db, e1_da, e1_db, p_da, p_db} = '0;
      return;
    end
    busy  = (clear_left > 0);
    acc_a = en_a && !busy;
    acc_b = en_b && !busy;
    wa    = acc_a && we_a;
    wb    = acc_b && we_b;
    old_a = m_mem[addr_a];
    old_b = m_mem[addr_b];
    e_coll = wa && wb && (addr_a == addr_b);
    if (wb) m_mem[addr_b] = din_b;
    if (wa) m_mem[addr_a] = din_a;
    e0_va = acc_a; if (acc_a) e0_da = old_a;
    e0_vb = acc_b; if (acc_b) e0_db = old_b;
    e1_va = p_va;  if (p_va) e1_da = p_da;
    e1_vb = p_vb;  if (p_vb) e1_db = p_db;
    p_va = acc_a;  if (acc_a) p_da = wa ? din_a : old_a;
    p_vb = acc_b;  if (acc_b) p_db = wb ? din_b : old_b;
    if (busy) clear_left--;
    else if (clr_i) begin
      clear_left = DEPTH / 2;
      foreach (m_mem[i]) m_mem[i] = '0;
    end
  endtask

  task automatic check_all();
    chk("busy0", busy0, clear_left > 0);
    chk("busy1", busy1, clear_left > 0);
    chk("vld0_a", vld0_a, e0_va);   chk("dout0_a", dout0_a, e0_da);
    chk("vld0_b", vld0_b, e0_vb);   chk("dout0_b", dout0_b, e0_db);
    chk("vld1_a", vld1_a, e1_va);   chk("dout1_a", dout1_a, e1_da);
    chk("vld1_b", vld1_b, e1_vb);   chk("dout1_b", dout1_b, e1_db);
    chk("coll0", coll0, e_coll);    chk("coll1", coll1, e_coll);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    {en_a, we_a, en_b, we_b, clr_i, rst_i} = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy0 === 1'b1 && n < 200) begin
      n++;
      idle_in();
      cycle();
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      idle_in();
      en_a = 1; addr_a = ADW'(i);
      en_b = 1; addr_b = ADW'(DEPTH - 1 - i);
      cycle();
      chk({tag, "_vld_a"}, vld0_a, 1'b1);
      chk({tag, "_zero_a"}, dout0_a, '0);
      chk({tag, "_zero_b"}, dout0_b, '0);
    end
    idle_in();
  endtask

  task automatic fill_all(input logic [DW-1:0] v);
    for (int i = 0; i < DEPTH / 2; i++) begin
      idle_in();
      en_a = 1; we_a = 1; addr_a = ADW'(2 * i);     din_a = v;
      en_b = 1; we_b = 1; addr_b = ADW'(2 * i + 1); din_b = v;
      cycle();
    end
    idle_in();
  endtask

  typedef struct packed {
    logic           en_a, we_a;
    logic [ADW-1:0] addr_a;
    logic [DW-1:0]  din_a;
    logic           en_b, we_b;
    logic [ADW-1:0] addr_b;
    logic [DW-1:0]  din_b;
    logic           x_va;
    logic [DW-1:0]  x_da;
    logic           x_vb;
    logic [DW-1:0]  x_db;
    logic           x_coll;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int n;
    vecs[0]  = '{1, 1, 5'd7, 12'hABC, 0, 0, 5'd0, 12'h000, 1, 12'h000, 0, 12'h000, 0};
    vecs[1]  = '{0, 0, 5'd0, 12'h000, 1, 0, 5'd7, 12'h000, 0, 12'h000, 1, 12'hABC, 0};
    vecs[2]  = '{1, 1, 5'd3, 12'h111, 0, 0, 5'd0, 12'h000, 1, 12'h000, 0, 12'hABC, 0};
    vecs[3]  = '{1, 1, 5'd3, 12'h222, 0, 0, 5'd0, 12'h000, 1, 12'h111, 0, 12'hABC, 0};
    vecs[4]  = '{1, 0, 5'd3, 12'h000, 0, 0, 5'd0, 12'h000, 1, 12'h222, 0, 12'hABC, 0};
    vecs[5]  = '{1, 1, 5'd9, 12'h0AA, 1, 1, 5'd9, 12'h0BB, 1, 12'h000, 1, 12'h000, 1};
    vecs[6]  = '{0, 0, 5'd0, 12'h000, 0, 0, 5'd0, 12'h000, 0, 12'h000, 0, 12'h000, 0};
    vecs[7]  = '{0, 0, 5'd0, 12'h000, 1, 0, 5'd9, 12'h000, 0, 12'h000, 1, 12'h0AA, 0};
    vecs[8]  = '{1, 1, 5'd4, 12'h050, 0, 0, 5'd0, 12'h000, 1, 12'h000, 0, 12'h0AA, 0};
    vecs[9]  = '{1, 1, 5'd4, 12'h060, 1, 0, 5'd4, 12'h000, 1, 12'h050, 1, 12'h050, 0};
    vecs[10] = '{0, 0, 5'd0, 12'h000, 1, 0, 5'd4, 12'h000, 0, 12'h050, 1, 12'h060, 0};

    // Reset and the clear that follows it.
    idle_in();
    rst_i = 1;
    cycle();
    rst_i = 0;
    chk("rst_busy", busy0, 1'b1);
    chk("rst_vld_a", vld0_a, 1'b0);
    chk("rst_dout_a", dout0_a, '0);
    chk("rst_coll", coll0, 1'b0);
    count_busy(n);
    chk("busy_len_after_reset", n, 16);
    read_all_zero("post_reset");

    // Directed vectors, read-first / latency-1 instance.
    foreach (vecs[k]) begin
      idle_in();
      {en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b} =
        {vecs[k].en_a, vecs[k].we_a, vecs[k].addr_a, vecs[k].din_a,
         vecs[k].en_b, vecs[k].we_b, vecs[k].addr_b, vecs[k].din_b};
      cycle();
      chk($sformatf("vec%0d_vld_a", k), vld0_a, vecs[k].x_va);
      chk($sformatf("vec%0d_dout_a", k), dout0_a, vecs[k].x_da);
      chk($sformatf("vec%0d_vld_b", k), vld0_b, vecs[k].x_vb);
      chk($sformatf("vec%0d_dout_b", k), dout0_b, vecs[k].x_db);
      chk($sformatf("vec%0d_coll", k), coll0, vecs[k].x_coll);
    end

    // Latency 2 on the output-registered instance.
    idle_in(); cycle(); cycle();
    en_b = 1; addr_b = 5'd7;
    cycle();
    chk("lat1_vld_b", vld0_b, 1'b1);
    chk("lat2_early_vld_b", vld1_b, 1'b0);
    idle_in();
    cycle();
    chk("lat2_vld_b", vld1_b, 1'b1);
    chk("lat2_dout_b", dout1_b, 12'hABC);

    // Write-first read-back on the same port.
    cycle();
    en_a = 1; we_a = 1; addr_a = 5'd3; din_a = 12'h333;
    cycle();
    chk("rdw_first_old", dout0_a, 12'h222);
    idle_in();
    cycle();
    chk("rdw_write_first", dout1_a, 12'h333);

    // Clear with a redundant request mid-sweep and user traffic during busy.
    fill_all(12'hFFF);
    clr_i = 1;
    cycle();
    n = 0;
    while (busy0 === 1'b1 && n < 200) begin
      n++;
      idle_in();
      en_a = 1; we_a = 1'($urandom); addr_a = ADW'($urandom); din_a = 12'h123;
      en_b = 1; we_b = 1'($urandom); addr_b = ADW'($urandom); din_b = 12'h456;
      clr_i = (n == 5);
      cycle();
      chk("busy_no_vld_a", vld0_a, 1'b0);
      chk("busy_no_vld_b", vld0_b, 1'b0);
    end
    chk("busy_len_second_clr", n, 16);
    read_all_zero("post_clear");

    // Reset at clear cycle 10 restarts the sweep.
    fill_all(12'hFFF);
    clr_i = 1;
    cycle();
    clr_i = 0;
    for (int k = 1; k < 10; k++) cycle();
    rst_i = 1;
    cycle();
    rst_i = 0;
    count_busy(n);
    chk("busy_len_after_restart", n, 16);
    read_all_zero("post_restart");

    // Randomized traffic against the model, collisions encouraged.
    for (int k = 0; k < 800; k++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      rst_i  = ($urandom_range(0, 299) == 0);
      clr_i  = ($urandom_range(0, 59) == 0);
      en_a   = 1'($urandom); we_a = 1'($urandom);
      en_b   = 1'($urandom); we_b = 1'($urandom);
      addr_a = narrow ? ADW'($urandom_range(0, 3)) : ADW'($urandom);
      addr_b = narrow ? ADW'($urandom_range(0, 3)) : ADW'($urandom);
      din_a  = DW'($urandom);
      din_b  = DW'($urandom);
      cycle();
    end
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_bram_tdp_clr.md
Name: ntt_bram_tdp_clr

Overview:
Parametrised true dual-port block RAM for the NTT coefficient banks. It is a successor to the fixed 32x12 dual-port RAM, with these additions:
- configurable depth, width, read-during-write mode and optional output register;
- per-port enables with read-valid strobes;
- deterministic write-collision arbitration;
- a hardware clear sequencer that zeroes the array after reset or on request.

Both NTT butterfly units read and write through it.

Parameters:
DATA_WIDTH, 12, coefficient width in bits (>=1)
ADW, 5, address width; DEPTH = 2**ADW words (ADW >= 1)
RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2

Ports:
clk_i  input  1  single clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
clr_i  input  1  single-cycle request to zero the whole array
busy_o  output  1  high while the clear sequence runs; user access ignored
en_a  input  1  port A access enable
we_a  input  1  port A write enable (qualified by en_a)
addr_a  input  ADW  port A address
din_a  input  DATA_WIDTH  port A write data
dout_a  output  DATA_WIDTH  port A read data
vld_a  output  1  port A read data valid strobe
en_b, we_b, addr_b, din_b, dout_b, vld_b  same as port A, for port B
coll_o  output  1  one-cycle pulse: both ports wrote the same address

Behaviour:
- Reset, sampled while rst_i=1:
  - dout_a, dout_b, vld_a, vld_b and coll_o all go to 0; pipeline stages are cleared.
  - The FSM enters CLEAR with clear counter = 0; busy_o=1 from the first cycle after rst_i is sampled high.
  - Reset asserted mid-operation (including mid-clear) aborts and restarts the clear from address 0.
- FSM states are CLEAR and IDLE.
  - CLEAR, each cycle: port A writes 0 to address cnt, port B writes 0 to cnt+1, then cnt += 2.
  - After the cycle writing DEPTH-2 and DEPTH-1, go to IDLE. CLEAR lasts exactly DEPTH/2 cycles, during which busy_o=1.
  - IDLE: busy_o=0. clr_i=1 sampled in IDLE -> CLEAR next cycle, cnt=0.
  - clr_i during CLEAR is ignored (no restart).
- User access:
  - While busy_o=1, en_a/en_b are ignored: no write, no read, vld stays 0, dout holds.
  - en=1, we=0: read. dout is updated and vld pulses 1 cycle, 1+OUT_REG cycles after the request.
  - en=1, we=1: write din to addr. dout and vld follow RD_MODE: a write is also a read of that address.
    - RD_MODE=0: old content.
    - RD_MODE=1: din.
  - en=0: no access. dout holds its last value; vld=0.
- Collisions and cross-port reads:
  - Both ports write the same address in the same cycle: port A's data is stored.
    - Port B's own read-back still follows RD_MODE with din_b.
    - coll_o pulses 1 on the next cycle (latency 1, independent of OUT_REG).
  - Cross-port same address, one writes and the other reads: the reader returns the old content, regardless of RD_MODE.
  - Different addresses: fully independent, 1 access per port per cycle.
- vld and dout for each port are registered together. With OUT_REG=1 both pass through the second stage; no bubbles, one result per cycle in flight.
- Address wrap: not applicable. All 2**ADW addresses are valid; no out-of-range case exists.

Test Plan:
- Reset then clear, default params: rst_i=1 for 1 cycle.
  - busy_o=1 for exactly 16 cycles, then 0.
  - Reading addresses 0..31 afterwards returns 0x000, each with vld_a=1 one cycle after its request.
- Write/read, port A:
  - Write 0xABC to addr 7 via port A.
  - Next cycle, read addr 7 on port B -> dout_b=0xABC, vld_b=1, latency 1.
  - With OUT_REG=1 the latency is 2.
- Read-during-write, same port, addr 3 holding 0x111; write 0x222 to addr 3 on port A:
  - RD_MODE=0 -> dout_a=0x111.
  - RD_MODE=1 -> dout_a=0x222.
  - Addr 3 then reads 0x222.
- Collision: same cycle, A writes 0x0AA and B writes 0x0BB to addr 9.
  - coll_o=1 for one cycle.
  - A subsequent read of addr 9 returns 0x0AA.
- Cross-port: addr 4 holds 0x050. A writes 0x060 to addr 4 while B reads addr 4.
  - dout_b=0x050.
  - Next B read of addr 4 -> 0x060.
- Clear interaction: fill all addresses with 0xFFF, then pulse clr_i.
  - Accesses issued during busy produce no vld and no write.
  - A second clr_i at clear cycle 5 does not extend busy (16 cycles total).
  - rst_i at clear cycle 10 restarts: busy lasts 16 more cycles.
  - Afterwards all addresses read 0.
